// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryption engine.
package arc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WAIT_LEN,
        WR_LEN,
        INC_I,
        WAIT_SI,
        ADD_J,
        WAIT_SJ,
        SWAP_I,
        SWAP_J,
        RD_PAD,
        WAIT_PAD,
        WR_CT,
        DONE
    } state_t;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;
    localparam logic [7:0] LEN_ADDR = 8'h00;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 PRGA encryption engine: length-prefixed PT -> CT, swapping S in place.
// Optional plaintext printable flag enabled by ARC4_ENC_PRINTABLE_CHECK_EN.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter logic [7:0] MSG_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    ,
    output logic       pt_printable
`endif
);

    state_t     r_state, w_state_next;
    logic [7:0] r_i, r_j, r_k, r_len, r_si, r_sj;
    logic [7:0] w_i_next, w_j_next, w_k_next, w_len_next, w_si_next, w_sj_next;
    logic [7:0] r_s_addr, r_s_wrdata, r_pt_addr, r_ct_addr, r_ct_wrdata;

    assign rdy = (r_state == IDLE);

    // Addresses are driven combinationally in the issuing state and held by
    // registers through the following WAIT so the synchronous memories keep
    // returning the same word into the consuming state.
    always_comb begin
        w_state_next = r_state;
        w_i_next     = r_i;
        w_j_next     = r_j;
        w_k_next     = r_k;
        w_len_next   = r_len;
        w_si_next    = r_si;
        w_sj_next    = r_sj;
        s_addr       = r_s_addr;
        s_wrdata     = r_s_wrdata;
        s_wren       = 1'b0;
        pt_addr      = r_pt_addr;
        ct_addr      = r_ct_addr;
        ct_wrdata    = r_ct_wrdata;
        ct_wren      = 1'b0;
        case (r_state)
            IDLE:     if (en) w_state_next = RD_LEN;
            RD_LEN: begin
                pt_addr      = LEN_ADDR;
                w_state_next = WAIT_LEN;
            end
            WAIT_LEN: w_state_next = WR_LEN;
            WR_LEN: begin
                w_len_next   = (pt_rddata >= MSG_MAX) ? MSG_MAX : pt_rddata;
                ct_addr      = LEN_ADDR;
                ct_wrdata    = w_len_next;
                ct_wren      = 1'b1;
                w_i_next     = 8'd0;
                w_j_next     = 8'd0;
                w_k_next     = 8'd1;
                w_state_next = (w_len_next == 8'd0) ? DONE : INC_I;
            end
            INC_I: begin
                w_i_next     = r_i + 8'd1;
                s_addr       = w_i_next;
                w_state_next = WAIT_SI;
            end
            WAIT_SI:  w_state_next = ADD_J;
            ADD_J: begin
                w_si_next    = s_rddata;
                w_j_next     = r_j + s_rddata;
                s_addr       = w_j_next;
                w_state_next = WAIT_SJ;
            end
            WAIT_SJ:  w_state_next = SWAP_I;
            SWAP_I: begin
                w_sj_next    = s_rddata;
                s_addr       = r_i;
                s_wrdata     = s_rddata;
                s_wren       = 1'b1;
                w_state_next = SWAP_J;
            end
            SWAP_J: begin
                s_addr       = r_j;
                s_wrdata     = r_si;
                s_wren       = 1'b1;
                w_state_next = RD_PAD;
            end
            RD_PAD: begin
                s_addr       = r_si + r_sj;
                pt_addr      = r_k;
                w_state_next = WAIT_PAD;
            end
            WAIT_PAD: w_state_next = WR_CT;
            WR_CT: begin
                ct_addr   = r_k;
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
                if (r_k == r_len) begin
                    w_state_next = DONE;
                end else begin
                    w_k_next     = r_k + 8'd1;
                    w_state_next = INC_I;
                end
            end
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_k         <= 8'd0;
            r_len       <= 8'd0;
            r_si        <= 8'd0;
            r_sj        <= 8'd0;
            r_s_addr    <= 8'd0;
            r_s_wrdata  <= 8'd0;
            r_pt_addr   <= 8'd0;
            r_ct_addr   <= 8'd0;
            r_ct_wrdata <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_i         <= w_i_next;
            r_j         <= w_j_next;
            r_k         <= w_k_next;
            r_len       <= w_len_next;
            r_si        <= w_si_next;
            r_sj        <= w_sj_next;
            r_s_addr    <= s_addr;
            r_s_wrdata  <= s_wrdata;
            r_pt_addr   <= pt_addr;
            r_ct_addr   <= ct_addr;
            r_ct_wrdata <= ct_wrdata;
        end
    end

`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    logic r_printable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_printable <= 1'b1;
        end else if (r_state == IDLE && en) begin
            r_printable <= 1'b1;
        end else if (r_state == WR_CT && !is_printable(pt_rddata)) begin
            r_printable <= 1'b0;
        end
    end

    assign pt_printable = r_printable;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: table vectors, random runs against a
// software PRGA model, and handshake / reset corner sequences.
module tb_arc4_encrypt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata;
    logic       s_wren, ct_wren;
    logic [7:0] s_q, pt_q;
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    logic       pt_printable;
`endif

    arc4_encrypt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_q),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_q),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        ,
        .pt_printable (pt_printable)
`endif
    );

    always #5 clk = ~clk;

    // Memories with synchronous read; S/CT are (re)loaded in one cycle via s_load.
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_src [256];
    logic       s_load = 1'b0;

    always @(posedge clk) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) begin
                s_mem[x]  <= s_src[x];
                ct_mem[x] <= 8'h00;
            end
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
        end
        s_q  <= s_mem[s_addr];
        pt_q <= pt_mem[pt_addr];
    end

    int s_wr_total = 0, ct_wr_total = 0, idle_wr_total = 0;
    always @(negedge clk) begin
        if (s_wren)  s_wr_total  <= s_wr_total + 1;
        if (ct_wren) ct_wr_total <= ct_wr_total + 1;
        if (rdy && (s_wren || ct_wren)) idle_wr_total <= idle_wr_total + 1;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: textbook ARC4 PRGA over plain arrays.
    logic [7:0] ref_s [256];
    logic [7:0] ref_ct [256];
    int         ref_len;
    bit         ref_printable;

    task automatic model_run();
        int i = 0, j = 0;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) ref_s[x] = s_src[x];
        ref_len = int'(pt_mem[0]);
        ref_ct[0] = pt_mem[0];
        ref_printable = 1'b1;
        for (int k = 1; k <= ref_len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(ref_s[i])) % 256;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
            ref_ct[k] = pt_mem[k] ^ ref_s[(int'(ref_s[i]) + int'(ref_s[j])) % 256];
            if (pt_mem[k] < 8'h20 || pt_mem[k] > 8'h7E) ref_printable = 1'b0;
        end
    endtask

    task automatic load_s();
        @(negedge clk); s_load = 1'b1;
        @(negedge clk); s_load = 1'b0;
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) s_src[x] = 8'(x);
    endtask

    // mode 0: single en pulse; mode 1: en held, then an extra mid-run pulse.
    task automatic run_dut(input int mode, output int cycles);
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        if (mode == 0) en = 1'b0;
        cycles = 0;
        while (!rdy && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            if (mode == 1) en = (cycles < 10) || (cycles == 20);
        end
        en = 1'b0;
    endtask

    task automatic verify(input string tag, input int cyc, input int sw0, input int cw0, input int iw0);
        int bad_s = 0;
        check({tag, " cycles"}, cyc, 4 + 9 * ref_len);
        check({tag, " s_wren count"}, s_wr_total - sw0, 2 * ref_len);
        check({tag, " ct_wren count"}, ct_wr_total - cw0, ref_len + 1);
        check({tag, " wren while rdy"}, idle_wr_total - iw0, 0);
        for (int k = 0; k <= ref_len; k++)
            check($sformatf("%s ct[%0d]", tag, k), int'(ct_mem[k]), int'(ref_ct[k]));
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad_s++;
        check({tag, " S mismatching words"}, bad_s, 0);
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        check({tag, " pt_printable"}, int'(pt_printable), int'(ref_printable));
`endif
        $display("run %s len=%0d cycles=%0d ct[1]=%02h", tag, ref_len, cyc, ct_mem[1]);
    endtask

    task automatic full_run(input string tag, input int mode);
        int cyc, sw0, cw0, iw0;
        load_s();
        model_run();
        @(negedge clk);
        sw0 = s_wr_total; cw0 = ct_wr_total; iw0 = idle_wr_total;
        run_dut(mode, cyc);
        verify(tag, cyc, sw0, cw0, iw0);
    endtask

    typedef struct {
        int          len;
        logic [23:0] pt;
        logic [23:0] ct;
        int          cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc, cw0, guard;
        vecs[0] = '{3, 24'h414243, 24'h434744, 31};
        vecs[1] = '{0, 24'h000000, 24'h000000, 4};
        vecs[2] = '{1, 24'h410000, 24'h430000, 13};
        vecs[3] = '{2, 24'h414200, 24'h434700, 22};
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
        identity_s();

        repeat (3) @(negedge clk);
        check("reset rdy", int'(rdy), 1);
        check("reset s_wren", int'(s_wren), 0);
        check("reset ct_wren", int'(ct_wren), 0);
        check("reset s_addr", int'(s_addr), 0);
        check("reset pt_addr", int'(pt_addr), 0);
        check("reset ct_addr", int'(ct_addr), 0);
        check("reset ct_wrdata", int'(ct_wrdata), 0);
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        check("reset pt_printable", int'(pt_printable), 1);
`endif
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            identity_s();
            pt_mem[0] = 8'(vecs[v].len);
            for (int k = 1; k <= 3; k++) pt_mem[k] = vecs[v].pt[23 - 8 * (k - 1) -: 8];
            load_s();
            model_run();
            @(negedge clk);
            cw0 = ct_wr_total;
            run_dut(0, cyc);
            check($sformatf("vec%0d cycles", v), cyc, vecs[v].cyc);
            check($sformatf("vec%0d ct_wren count", v), ct_wr_total - cw0, vecs[v].len + 1);
            check($sformatf("vec%0d ct[0]", v), int'(ct_mem[0]), vecs[v].len);
            for (int k = 1; k <= vecs[v].len; k++)
                check($sformatf("vec%0d ct[%0d]", v, k), int'(ct_mem[k]),
                      int'(vecs[v].ct[23 - 8 * (k - 1) -: 8]));
            if (v == 0) begin
                check("vec0 S[2]", int'(s_mem[2]), 3);
                check("vec0 S[3]", int'(s_mem[3]), 5);
                check("vec0 S[5]", int'(s_mem[5]), 2);
            end
            $display("run vec%0d len=%0d cycles=%0d", v, vecs[v].len, cyc);
        end

        for (int r = 0; r < 8; r++) begin
            for (int x = 0; x < 256; x++) s_src[x] = 8'($urandom);
            pt_mem[0] = (r == 3) ? 8'd0 : 8'($urandom_range(40, 1));
            for (int k = 1; k < 256; k++) pt_mem[k] = 8'($urandom);
            full_run($sformatf("rand%0d", r), 0);
        end

        identity_s();
        pt_mem[0] = 8'd255;
        for (int k = 1; k < 256; k++) pt_mem[k] = 8'($urandom);
        full_run("len255", 0);

        for (int x = 0; x < 256; x++) s_src[x] = 8'($urandom);
        pt_mem[0] = 8'd5;
        full_run("en_held", 1);
        cw0 = ct_wr_total;
        repeat (6) @(negedge clk);
        check("en_held no restart rdy", int'(rdy), 1);
        check("en_held no restart writes", ct_wr_total - cw0, 0);

        identity_s();
        pt_mem[0] = 8'd3;
        pt_mem[1] = 8'h41; pt_mem[2] = 8'h42; pt_mem[3] = 8'h43;
        load_s();
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(ct_wren && ct_addr == 8'd2) && guard < 200) begin
            @(negedge clk); guard++;
        end
        check("midrun reached WR_CT k=2", int'(guard < 200), 1);
        rst_n = 1'b0;
        #1;
        check("midrun reset rdy", int'(rdy), 1);
        check("midrun reset s_wren", int'(s_wren), 0);
        check("midrun reset ct_wren", int'(ct_wren), 0);
        check("midrun reset ct_addr", int'(ct_addr), 0);
        check("midrun reset s_addr", int'(s_addr), 0);
        @(negedge clk); rst_n = 1'b1;
        full_run("after_reset", 0);

`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        identity_s();
        pt_mem[0] = 8'd2; pt_mem[1] = 8'h48; pt_mem[2] = 8'h0A;
        full_run("print_no", 0);
        check("printable PT 48,0A", int'(pt_printable), 0);
        pt_mem[2] = 8'h49;
        full_run("print_yes", 0);
        check("printable PT 48,49", int'(pt_printable), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 PRGA encryption engine; the write-side counterpart of the decrypt/crack path.
- Reads a length-prefixed plaintext from PT memory and an already key-scheduled S memory from the upstream init/KSA stage.
- Writes a length-prefixed ciphertext to CT memory, swapping S in place exactly as decrypt does.
- Used to generate test ciphertexts on-chip for the cracking flow; started and monitored through the same en/rdy handshake as the arc4 top.

Parameters:
- MSG_MAX, 255, largest accepted length byte; lengths above it are clamped to MSG_MAX.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request; honoured only while rdy=1
- rdy  output  1  high when idle and able to accept en
- s_addr  output  8  S memory address
- s_rddata  input  8  S memory read data
- s_wrdata  output  8  S memory write data
- s_wren  output  1  S memory write enable
- pt_addr  output  8  plaintext memory address
- pt_rddata  input  8  plaintext read data
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable

Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset, asynchronous, including mid-operation:
  - rdy=1; all wren=0; all addr/wrdata=0.
  - i, j, k, len cleared; FSM to IDLE.
  - S/CT contents are left as partially written.
- Memories: synchronous read. Address driven in state X, data sampled in the state after the following WAIT state.
- Handshake:
  - en sampled on the rising edge while rdy=1 starts a run; rdy goes 0 the next cycle.
  - en while rdy=0 is ignored.
  - rdy returns to 1 exactly 4+9*len cycles after the accepting edge.
- Header states:
  - RD_LEN: pt_addr=0.
  - WAIT_LEN.
  - WR_LEN: len=min(pt_rddata,MSG_MAX); ct_addr=0, ct_wrdata=len, ct_wren=1; i=0, j=0, k=1. If len==0, go to DONE.
- Per-byte loop, 9 states:
  - INC_I: i=i+1 mod 256; s_addr=i+1.
  - WAIT_SI.
  - ADD_J: si=s_rddata; j=j+si mod 256; s_addr=j+si.
  - WAIT_SJ.
  - SWAP_I: sj=s_rddata; s_addr=i, s_wrdata=sj, s_wren=1.
  - SWAP_J: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=si+sj mod 256; pt_addr=k.
  - WAIT_PAD.
  - WR_CT: ct_addr=k, ct_wrdata=pt_rddata^s_rddata, ct_wren=1. If k==len, go to DONE; else k=k+1 and go to INC_I.
- DONE: one cycle, then IDLE with rdy=1.
- Arithmetic: all index arithmetic is 8-bit wrap-around.
- i==j: both swap writes hit the same word; the final value is si, which is correct.
- The pad read follows both swap writes, so it sees the updated S.
- wren is high for exactly one cycle per write; it is never asserted in IDLE or DONE.

Optional Feature:
- Macro ARC4_ENC_PRINTABLE_CHECK_EN.
- Defined:
  - Adds output pt_printable (1 bit; reset 1, cleared on run start).
  - Cleared to 0 if any plaintext byte k=1..len lies outside 0x20..0x7E.
  - Valid when rdy rises; held until the next run.
- Undefined: port and logic absent; timing unchanged.

Decomposition:
- Package arc4_pkg:
  - state enum (IDLE, RD_LEN, WAIT_LEN, WR_LEN, INC_I, WAIT_SI, ADD_J, WAIT_SJ, SWAP_I, SWAP_J, RD_PAD, WAIT_PAD, WR_CT, DONE).
  - Constants PRINT_LO=8'h20, PRINT_HI=8'h7E, LEN_ADDR=8'h00.
- Single FSM module; no sub-module warranted.

Test Plan:
- Identity S (S[x]=x), PT={3,41,42,43}, pulse en -> CT={03,43,47,44}; S[2]=03, S[3]=05, S[5]=02; rdy high 31 cycles after accept.
- PT[0]=0 -> single CT write ct[0]=00; no s_wren; rdy back in 4 cycles.
- Length 255, identity S -> i wraps 255 without corruption; 255 CT bytes match the software PRGA model; 4+9*255 cycles.
- en held high during a run, plus a second pulse mid-run -> exactly one run; no restart.
- rst_n dropped at a WR_CT cycle -> rdy=1 and all wren=0 immediately (asynchronous); a fresh run then produces correct CT from re-initialised S.
- With ARC4_ENC_PRINTABLE_CHECK_EN: PT={2,48,0A} -> pt_printable=0; PT={2,48,49} -> pt_printable=1.
